// File: rtl/cart_bus_pkg.sv
// Shared types and constants for the cartridge bus controller.
// Optional build macro CART_RR_ARB_EN selects round-robin arbitration in cart_bus_arb.
package cart_bus_pkg;

  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_t;

  localparam logic [15:0] SRAM_BASE = 16'hA000;
  localparam logic [15:0] SRAM_LAST = 16'hBFFF;

  function automatic logic is_sram(input logic [15:0] addr);
    return (addr >= SRAM_BASE) && (addr <= SRAM_LAST);
  endfunction

endpackage

// File: rtl/cart_bus_arb.sv
// Two-input bus arbiter: fixed DMA-over-CPU priority by default,
// round-robin between the two requesters when CART_RR_ARB_EN is defined.
module cart_bus_arb
  import cart_bus_pkg::*;
(
`ifdef CART_RR_ARB_EN
  input  logic    i_clock,
  input  logic    i_reset_l,
  input  logic    i_accept,
`endif
  input  logic    i_cpu_req,
  input  logic    i_dma_req,
  output req_id_t o_gnt_id,
  output logic    o_gnt_valid
);

`ifdef CART_RR_ARB_EN
  req_id_t r_last_id;

  // Resetting to CPU makes DMA win the first tie.
  always_ff @(posedge i_clock) begin
    if (!i_reset_l) begin
      r_last_id <= REQ_CPU;
    end else if (i_accept) begin
      r_last_id <= o_gnt_id;
    end
  end

  always_comb begin
    o_gnt_valid = i_cpu_req | i_dma_req;
    if (i_cpu_req && i_dma_req) begin
      o_gnt_id = (r_last_id == REQ_CPU) ? REQ_DMA : REQ_CPU;
    end else begin
      o_gnt_id = i_dma_req ? REQ_DMA : REQ_CPU;
    end
  end
`else
  always_comb begin
    o_gnt_valid = i_cpu_req | i_dma_req;
    o_gnt_id    = i_dma_req ? REQ_DMA : REQ_CPU;
  end
`endif

endmodule

// File: rtl/cart_bus_ctrl.sv
// Cartridge bus sequencer: arbitrates CPU/DMA and runs SETUP/STROBE/HOLD cycles.
// Build macro CART_RR_ARB_EN switches the arbiter to round-robin.
module cart_bus_ctrl
  import cart_bus_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 3,
  parameter int HOLD_CYCLES   = 1,
  parameter int RESET_HOLD    = 16
) (
  input  logic        i_clock,
  input  logic        i_reset_l,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  output logic        o_cpu_ack,
  input  logic        i_dma_req,
  input  logic        i_dma_we,
  input  logic [15:0] i_dma_addr,
  input  logic [7:0]  i_dma_wdata,
  output logic        o_dma_ack,
  output logic [7:0]  o_rdata,
  output logic [15:0] o_cart_address,
  input  logic [7:0]  i_cart_data_in,
  output logic [7:0]  o_cart_data_out,
  output logic        o_cart_data_oe,
  output logic        o_cart_r_enable_l,
  output logic        o_cart_w_enable_l,
  output logic        o_cart_cs_sram_l,
  output logic        o_cart_reset_l,
  output logic        o_busy
);

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD   = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;
  localparam logic [7:0] RST_LOAD    = 8'(RESET_HOLD - 1);

  state_t      r_state;
  logic [3:0]  r_phase;
  logic [7:0]  r_rst_cnt;
  req_id_t     r_winner;
  logic        r_we;
  logic        r_cpu_ack, r_dma_ack;
  logic [7:0]  r_rdata;
  logic [15:0] r_cart_address;
  logic [7:0]  r_cart_data_out;
  logic        r_cart_data_oe, r_cart_r_enable_l, r_cart_w_enable_l;
  logic        r_cart_cs_sram_l, r_cart_reset_l, r_busy;

  req_id_t     w_gnt_id;
  logic        w_gnt_valid, w_grant, w_finish;
  logic        w_we;
  logic [15:0] w_addr;
  logic [7:0]  w_wdata;

  cart_bus_arb u_arb (
`ifdef CART_RR_ARB_EN
    .i_clock     (i_clock),
    .i_reset_l   (i_reset_l),
    .i_accept    (w_grant),
`endif
    .i_cpu_req   (i_cpu_req),
    .i_dma_req   (i_dma_req),
    .o_gnt_id    (w_gnt_id),
    .o_gnt_valid (w_gnt_valid)
  );

  // An ack in flight blocks granting so the just-served request is not re-run.
  assign w_grant  = (r_state == IDLE) && w_gnt_valid && !r_cpu_ack && !r_dma_ack;
  assign w_we     = (w_gnt_id == REQ_DMA) ? i_dma_we    : i_cpu_we;
  assign w_addr   = (w_gnt_id == REQ_DMA) ? i_dma_addr  : i_cpu_addr;
  assign w_wdata  = (w_gnt_id == REQ_DMA) ? i_dma_wdata : i_cpu_wdata;
  assign w_finish = (r_phase == 4'd0) &&
                    ((r_state == HOLD) || ((r_state == STROBE) && (HOLD_CYCLES == 0)));

  always_ff @(posedge i_clock) begin
    if (!i_reset_l) begin
      r_state           <= RST_HOLD;
      r_phase           <= 4'd0;
      r_rst_cnt         <= RST_LOAD;
      r_winner          <= REQ_CPU;
      r_we              <= 1'b0;
      r_cpu_ack         <= 1'b0;
      r_dma_ack         <= 1'b0;
      r_rdata           <= 8'h00;
      r_cart_address    <= 16'h0000;
      r_cart_data_out   <= 8'h00;
      r_cart_data_oe    <= 1'b0;
      r_cart_r_enable_l <= 1'b1;
      r_cart_w_enable_l <= 1'b1;
      r_cart_cs_sram_l  <= 1'b1;
      r_cart_reset_l    <= 1'b0;
      r_busy            <= 1'b1;
    end else begin
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      case (r_state)
        RST_HOLD: begin
          if (r_rst_cnt == 8'd0) begin
            r_state        <= IDLE;
            r_cart_reset_l <= 1'b1;
            r_busy         <= 1'b0;
          end else begin
            r_rst_cnt <= r_rst_cnt - 8'd1;
          end
        end
        IDLE: begin
          if (w_grant) begin
            r_state          <= SETUP;
            r_busy           <= 1'b1;
            r_phase          <= SETUP_LOAD;
            r_winner         <= w_gnt_id;
            r_we             <= w_we;
            r_cart_address   <= w_addr;
            r_cart_cs_sram_l <= !is_sram(w_addr);
            if (w_we) begin
              r_cart_data_out <= w_wdata;
              r_cart_data_oe  <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (r_phase == 4'd0) begin
            r_state           <= STROBE;
            r_phase           <= STROBE_LOAD;
            r_cart_r_enable_l <= r_we;
            r_cart_w_enable_l <= !r_we;
          end else begin
            r_phase <= r_phase - 4'd1;
          end
        end
        STROBE: begin
          if (r_phase == 4'd0) begin
            r_cart_r_enable_l <= 1'b1;
            r_cart_w_enable_l <= 1'b1;
            if (!r_we) begin
              r_rdata <= i_cart_data_in;
            end
            if (HOLD_CYCLES != 0) begin
              r_state <= HOLD;
              r_phase <= HOLD_LOAD;
            end
          end else begin
            r_phase <= r_phase - 4'd1;
          end
        end
        HOLD: begin
          if (r_phase != 4'd0) begin
            r_phase <= r_phase - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
      // Address and write data stay on the pins after completion.
      if (w_finish) begin
        r_state          <= IDLE;
        r_busy           <= 1'b0;
        r_cart_cs_sram_l <= 1'b1;
        r_cart_data_oe   <= 1'b0;
        r_cpu_ack        <= (r_winner == REQ_CPU);
        r_dma_ack        <= (r_winner == REQ_DMA);
      end
    end
  end

  assign o_cpu_ack         = r_cpu_ack;
  assign o_dma_ack         = r_dma_ack;
  assign o_rdata           = r_rdata;
  assign o_cart_address    = r_cart_address;
  assign o_cart_data_out   = r_cart_data_out;
  assign o_cart_data_oe    = r_cart_data_oe;
  assign o_cart_r_enable_l = r_cart_r_enable_l;
  assign o_cart_w_enable_l = r_cart_w_enable_l;
  assign o_cart_cs_sram_l  = r_cart_cs_sram_l;
  assign o_cart_reset_l    = r_cart_reset_l;
  assign o_busy            = r_busy;

endmodule

// File: tb/tb_cart_bus_ctrl.sv
// Scoreboard bench for cart_bus_ctrl: default-timing instance plus a HOLD_CYCLES=0 instance.
module tb_cart_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_l;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata, din;
  logic        cpu_ack, dma_ack, oe, r_en, w_en, cs, cart_reset_l, busy;
  logic [7:0]  rdata, dout;
  logic [15:0] addr;

  logic        h_cpu_req, h_cpu_we;
  logic [15:0] h_cpu_addr;
  logic [7:0]  h_cpu_wdata;
  logic        h_cpu_ack, h_dma_ack, h_oe, h_r_en, h_w_en, h_cs, h_cart_reset_l, h_busy;
  logic [7:0]  h_rdata, h_dout;
  logic [15:0] h_addr;

  cart_bus_ctrl u_dut (
    .i_clock(clk), .i_reset_l(reset_l),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ack(cpu_ack),
    .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
    .o_dma_ack(dma_ack),
    .o_rdata(rdata), .o_cart_address(addr), .i_cart_data_in(din), .o_cart_data_out(dout),
    .o_cart_data_oe(oe), .o_cart_r_enable_l(r_en), .o_cart_w_enable_l(w_en),
    .o_cart_cs_sram_l(cs), .o_cart_reset_l(cart_reset_l), .o_busy(busy)
  );

  cart_bus_ctrl #(.HOLD_CYCLES(0)) u_h0 (
    .i_clock(clk), .i_reset_l(reset_l),
    .i_cpu_req(h_cpu_req), .i_cpu_we(h_cpu_we), .i_cpu_addr(h_cpu_addr), .i_cpu_wdata(h_cpu_wdata),
    .o_cpu_ack(h_cpu_ack),
    .i_dma_req(1'b0), .i_dma_we(1'b0), .i_dma_addr(16'h0000), .i_dma_wdata(8'h00),
    .o_dma_ack(h_dma_ack),
    .o_rdata(h_rdata), .o_cart_address(h_addr), .i_cart_data_in(din), .o_cart_data_out(h_dout),
    .o_cart_data_oe(h_oe), .o_cart_r_enable_l(h_r_en), .o_cart_w_enable_l(h_w_en),
    .o_cart_cs_sram_l(h_cs), .o_cart_reset_l(h_cart_reset_l), .o_busy(h_busy)
  );

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       is_dma;
    logic       we;
    logic [7:0] rdata;
    int         due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (cpu_ack || dma_ack) begin
      chk("ack_single", {31'd0, cpu_ack & dma_ack}, 32'd0);
      chk("ack_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        $display("txn cyc=%0d %s %s rdata=%02h addr=%04h", cyc, dma_ack ? "DMA" : "CPU",
                 mon_e.we ? "WR" : "RD", rdata, addr);
        chk("ack_id", {31'd0, dma_ack}, {31'd0, mon_e.is_dma});
        chk("ack_cycle", cyc, mon_e.due);
        if (!mon_e.we) chk("rdata", {24'd0, rdata}, {24'd0, mon_e.rdata});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c0;
    int  wlow;
    bit  got, dma_done, cpu_done;

    reset_l = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100; cpu_wdata = 8'h00;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 8'h00;
    h_cpu_req = 1'b0; h_cpu_we = 1'b0; h_cpu_addr = 16'h0000; h_cpu_wdata = 8'h00;
    din = 8'h3C;

    // Reset: values while held low, then a 16-cycle cartridge reset pulse.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cart_reset", {31'd0, cart_reset_l}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_strobes", {30'd0, r_en, w_en}, 32'd3);
    chk("rst_cs_oe", {30'd0, cs, oe}, 32'd2);
    chk("rst_addr", {16'd0, addr}, 32'd0);
    chk("rst_dout_rdata", {16'd0, dout, rdata}, 32'd0);
    chk("rst_h0_busy", {31'd0, h_busy}, 32'd1);
    tick();
    reset_l = 1'b1;
    c0 = cyc;
    sb.push_back('{1'b0, 1'b0, 8'h3C, c0 + 22});
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      chk("rst_pulse", {31'd0, cart_reset_l}, (k < 16) ? 32'd0 : 32'd1);
      chk("rst_hold_busy", {31'd0, busy}, (k < 16) ? 32'd1 : 32'd0);
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cpu_ack) got = 1'b1;
    end
    chk("post_rst_ack", {31'd0, got}, 32'd1);
    tick();
    cpu_req = 1'b0;

    // CPU read of the header byte at 0x0147.
    repeat (2) tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0147; din = 8'h13;
    c0 = cyc;
    sb.push_back('{1'b0, 1'b0, 8'h13, c0 + 6});
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        chk("rd_r_en", {31'd0, r_en}, (k >= 2 && k <= 4) ? 32'd0 : 32'd1);
        chk("rd_w_en", {31'd0, w_en}, 32'd1);
        chk("rd_cs", {31'd0, cs}, 32'd1);
        chk("rd_addr", {16'd0, addr}, 32'h0147);
        chk("rd_busy", {31'd0, busy}, (k <= 5) ? 32'd1 : 32'd0);
      end
    end
    tick();
    cpu_req = 1'b0;

    // DMA write into cartridge SRAM.
    repeat (2) tick();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'hA123; dma_wdata = 8'h5A; din = 8'hEE;
    c0 = cyc;
    sb.push_back('{1'b1, 1'b1, 8'h00, c0 + 6});
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        chk("wr_cs", {31'd0, cs}, (k <= 5) ? 32'd0 : 32'd1);
        chk("wr_oe", {31'd0, oe}, (k <= 5) ? 32'd1 : 32'd0);
        chk("wr_w_en", {31'd0, w_en}, (k >= 2 && k <= 4) ? 32'd0 : 32'd1);
        chk("wr_r_en", {31'd0, r_en}, 32'd1);
        chk("wr_dout", {24'd0, dout}, 32'h5A);
        chk("wr_addr", {16'd0, addr}, 32'hA123);
        chk("wr_rdata_held", {24'd0, rdata}, 32'h13);
      end
    end
    tick();
    dma_req = 1'b0;

    // Both requesters together, both held until their own ack.
    repeat (2) tick();
    din = 8'h42;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h4000; dma_wdata = 8'h99;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hB000;
    c0 = cyc;
`ifdef CART_RR_ARB_EN
    sb.push_back('{1'b0, 1'b0, 8'h42, c0 + 6});
    sb.push_back('{1'b1, 1'b1, 8'h00, c0 + 13});
`else
    sb.push_back('{1'b1, 1'b1, 8'h00, c0 + 6});
    sb.push_back('{1'b0, 1'b0, 8'h42, c0 + 13});
`endif
    dma_done = 1'b0;
    cpu_done = 1'b0;
    for (int i = 0; i < 30 && !(dma_done && cpu_done); i++) begin
      @(negedge clk);
      if (dma_ack) dma_done = 1'b1;
      if (cpu_ack) cpu_done = 1'b1;
      tick();
      if (dma_done) dma_req = 1'b0;
      if (cpu_done) cpu_req = 1'b0;
    end
    chk("pair_done", {30'd0, dma_done, cpu_done}, 32'd3);

    // Reset asserted mid-STROBE of a read aborts without ack.
    repeat (2) tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0150; din = 8'h77;
    for (int k = 0; k <= 2; k++) @(negedge clk);
    chk("abort_in_strobe", {31'd0, r_en}, 32'd0);
    tick();
    reset_l = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_r_en", {31'd0, r_en}, 32'd1);
    chk("abort_cart_reset", {31'd0, cart_reset_l}, 32'd0);
    chk("abort_rdata", {24'd0, rdata}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    chk("abort_addr", {16'd0, addr}, 32'd0);
    tick();
    cpu_req = 1'b0;
    reset_l = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cart_reset_l && h_cart_reset_l) got = 1'b1;
    end
    chk("abort_recover", {31'd0, got}, 32'd1);

    // HOLD_CYCLES=0 instance: MBC register write, chip-select never asserted.
    repeat (2) tick();
    h_cpu_req = 1'b1; h_cpu_we = 1'b1; h_cpu_addr = 16'h2000; h_cpu_wdata = 8'h01;
    wlow = 0;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        if (!h_w_en) wlow++;
        chk("h0_cs", {31'd0, h_cs}, 32'd1);
        chk("h0_w_en", {31'd0, h_w_en}, (k >= 2 && k <= 4) ? 32'd0 : 32'd1);
        chk("h0_ack", {30'd0, h_cpu_ack, h_dma_ack}, (k == 5) ? 32'd2 : 32'd0);
        chk("h0_oe", {31'd0, h_oe}, (k <= 4) ? 32'd1 : 32'd0);
      end
    end
    chk("h0_strobe_len", wlow, 3);
    chk("h0_dout", {16'd0, h_addr[15:8], h_dout}, 32'h2001);
    $display("txn cyc=%0d H0 CPU WR addr=%04h data=%02h", cyc, h_addr, h_dout);
    tick();
    h_cpu_req = 1'b0;

    repeat (3) tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
